// File: rtl/hit_detector.sv
// Bullet/alien coincidence detector: maps a hit pixel to a formation cell and hands the kill over via valid/ready.
// Optional hit counter enabled by defining HIT_DETECTOR_HIT_COUNT_EN; otherwise hit_count is tied to zero.
module hit_detector #(
    parameter int NUM_ROWS    = 2,
    parameter int NUM_COLUMNS = 4,
    parameter int COL_SHIFT   = 6,
    parameter int ROW_SHIFT   = 5,
    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
    localparam int COL_W = (NUM_COLUMNS > 1) ? $clog2(NUM_COLUMNS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic [15:0]      scan_x,
    input  logic [15:0]      scan_y,
    input  logic [15:0]      origin_x,
    input  logic [15:0]      origin_y,
    input  logic             alien_pixel,
    input  logic             bullet_pixel,
    output logic             kill_valid,
    input  logic             kill_ready,
    output logic [ROW_W-1:0] kill_row,
    output logic [COL_W-1:0] kill_col,
    output logic             bullet_consume,
    output logic [15:0]      hit_count
);

    typedef enum logic [1:0] {
        ARMED    = 2'd0,
        PENDING  = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    state_t      state;
    logic        frame_seen;
    logic        coincide;
    logic [15:0] dx;
    logic [15:0] dy;
    logic [15:0] col_full;
    logic [15:0] row_full;
    logic        in_grid;
    logic        hit;
    logic        accept;

    // Offsets wrap when the scan is left/above the grid; the explicit compares reject those.
    assign coincide = alien_pixel & bullet_pixel;
    assign dx       = scan_x - origin_x;
    assign dy       = scan_y - origin_y;
    assign col_full = dx >> COL_SHIFT;
    assign row_full = dy >> ROW_SHIFT;
    assign in_grid  = (scan_x >= origin_x) && (scan_y >= origin_y) &&
                      (col_full < 16'(NUM_COLUMNS)) && (row_full < 16'(NUM_ROWS));
    assign hit      = coincide && in_grid;
    assign accept   = (state == PENDING) && kill_valid && kill_ready;

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ARMED;
            frame_seen     <= 1'b0;
            kill_valid     <= 1'b0;
            kill_row       <= '0;
            kill_col       <= '0;
            bullet_consume <= 1'b0;
        end else begin
            bullet_consume <= 1'b0;
            case (state)
                ARMED: begin
                    // A frame_start in the capture cycle is absorbed: the new frame begins with this kill.
                    if (hit) begin
                        kill_row       <= row_full[ROW_W-1:0];
                        kill_col       <= col_full[COL_W-1:0];
                        kill_valid     <= 1'b1;
                        bullet_consume <= 1'b1;
                        frame_seen     <= 1'b0;
                        state          <= PENDING;
                    end
                end
                PENDING: begin
                    if (frame_start) begin
                        frame_seen <= 1'b1;
                    end
                    // A frame boundary crossed while waiting means cooldown is already over.
                    if (accept) begin
                        kill_valid <= 1'b0;
                        frame_seen <= 1'b0;
                        state      <= (frame_seen || frame_start) ? ARMED : COOLDOWN;
                    end
                end
                COOLDOWN: begin
                    if (frame_start) begin
                        state <= ARMED;
                    end
                end
                default: begin
                    state      <= ARMED;
                    kill_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef HIT_DETECTOR_HIT_COUNT_EN
    logic [15:0] hit_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count_q <= '0;
        end else if (accept && (hit_count_q != 16'hFFFF)) begin
            hit_count_q <= hit_count_q + 16'd1;
        end
    end

    assign hit_count = hit_count_q;
`else
    assign hit_count = 16'd0;
`endif

endmodule

// File: tb/tb_hit_detector.sv
// Scoreboard bench for hit_detector: expected kills are queued at stimulus time and popped when kill_valid rises.
module tb_hit_detector;

    localparam int ROW_W = 1;
    localparam int COL_W = 2;

    typedef struct {
        int row;
        int col;
    } kill_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             frame_start;
    logic [15:0]      scan_x;
    logic [15:0]      scan_y;
    logic [15:0]      origin_x;
    logic [15:0]      origin_y;
    logic             alien_pixel;
    logic             bullet_pixel;
    logic             kill_valid;
    logic             kill_ready;
    logic [ROW_W-1:0] kill_row;
    logic [COL_W-1:0] kill_col;
    logic             bullet_consume;
    logic [15:0]      hit_count;

    kill_t sb[$];
    kill_t last_kill;
    int    vectors = 0;
    int    miscompares = 0;
    int    exp_hits = 0;

    hit_detector dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .frame_start    (frame_start),
        .scan_x         (scan_x),
        .scan_y         (scan_y),
        .origin_x       (origin_x),
        .origin_y       (origin_y),
        .alien_pixel    (alien_pixel),
        .bullet_pixel   (bullet_pixel),
        .kill_valid     (kill_valid),
        .kill_ready     (kill_ready),
        .kill_row       (kill_row),
        .kill_col       (kill_col),
        .bullet_consume (bullet_consume),
        .hit_count      (hit_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one coincidence cycle and checks the registered response on the following edge.
    task automatic coincide(input string tag, input int x, input int y, input bit exp_hit,
                            input int er, input int ec, input bit with_frame);
        kill_t e;
        scan_x       = 16'(x);
        scan_y       = 16'(y);
        alien_pixel  = 1'b1;
        bullet_pixel = 1'b1;
        frame_start  = with_frame;
        if (exp_hit) begin
            e.row = er;
            e.col = ec;
            sb.push_back(e);
        end
        tick();
        alien_pixel  = 1'b0;
        bullet_pixel = 1'b0;
        frame_start  = 1'b0;
        check({tag, "_valid"}, 32'(kill_valid), 32'(exp_hit));
        check({tag, "_consume"}, 32'(bullet_consume), 32'(exp_hit));
        if (kill_valid) begin
            if (sb.size() > 0) begin
                last_kill = sb.pop_front();
                check({tag, "_row"}, 32'(kill_row), 32'(last_kill.row));
                check({tag, "_col"}, 32'(kill_col), 32'(last_kill.col));
            end else begin
                check({tag, "_unexpected_kill"}, 32'(kill_valid), 32'd0);
            end
        end
    endtask

    task automatic hold(input string tag, input int n, input bit with_frame);
        for (int i = 0; i < n; i++) begin
            kill_ready  = 1'b0;
            frame_start = with_frame && (i == 0);
            tick();
            frame_start = 1'b0;
            check({tag, "_hold_valid"}, 32'(kill_valid), 32'd1);
            check({tag, "_hold_row"}, 32'(kill_row), 32'(last_kill.row));
            check({tag, "_hold_col"}, 32'(kill_col), 32'(last_kill.col));
            check({tag, "_hold_consume"}, 32'(bullet_consume), 32'd0);
        end
    endtask

    task automatic handshake(input string tag, input bit with_frame);
        kill_ready  = 1'b1;
        frame_start = with_frame;
        tick();
        kill_ready  = 1'b0;
        frame_start = 1'b0;
`ifdef HIT_DETECTOR_HIT_COUNT_EN
        exp_hits++;
`endif
        check({tag, "_hs_valid"}, 32'(kill_valid), 32'd0);
        check({tag, "_hs_count"}, 32'(hit_count), 32'(exp_hits));
    endtask

    task automatic frame_pulse();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        frame_start  = 1'b0;
        scan_x       = '0;
        scan_y       = '0;
        origin_x     = 16'd50;
        origin_y     = 16'd50;
        alien_pixel  = 1'b0;
        bullet_pixel = 1'b0;
        kill_ready   = 1'b0;
        last_kill.row = 0;
        last_kill.col = 0;
        tick();
        tick();
        check("rst_valid", 32'(kill_valid), 32'd0);
        check("rst_consume", 32'(bullet_consume), 32'd0);
        check("rst_row", 32'(kill_row), 32'd0);
        check("rst_col", 32'(kill_col), 32'd0);
        check("rst_count", 32'(hit_count), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic capture, long backpressure, handshake.
        coincide("basic", 180, 90, 1'b1, 1, 2, 1'b0);
        hold("basic", 10, 1'b0);
        handshake("basic", 1'b0);

        // Second hit in the same frame is ignored; next frame captures again.
        coincide("cooldown", 180, 90, 1'b0, 0, 0, 1'b0);
        frame_pulse();
        check("cooldown_quiet", 32'(kill_valid), 32'd0);
        coincide("newframe", 60, 60, 1'b1, 0, 0, 1'b0);
        handshake("newframe", 1'b0);
        frame_pulse();

        // Out-of-grid coincidences are discarded without leaving ARMED.
        coincide("left", 40, 60, 1'b0, 0, 0, 1'b0);
        coincide("right", 306, 60, 1'b0, 0, 0, 1'b0);
        coincide("above", 60, 40, 1'b0, 0, 0, 1'b0);
        coincide("below", 60, 114, 1'b0, 0, 0, 1'b0);
        coincide("corner", 305, 113, 1'b1, 1, 3, 1'b0);
        hold("corner", 2, 1'b0);

        // Asynchronous reset drops the pending kill mid-cycle.
        #2;
        rst_n = 1'b0;
        #1;
        exp_hits = 0;
        check("async_valid", 32'(kill_valid), 32'd0);
        check("async_row", 32'(kill_row), 32'd0);
        check("async_col", 32'(kill_col), 32'd0);
        check("async_count", 32'(hit_count), 32'd0);
        #1;
        rst_n = 1'b1;
        tick();
        coincide("post_rst", 180, 90, 1'b1, 1, 2, 1'b0);

        // frame_start while pending: kill survives, handshake returns straight to ARMED.
        hold("pend_frame", 2, 1'b1);
        handshake("pend_frame", 1'b0);
        coincide("rearmed", 241, 113, 1'b1, 1, 2, 1'b0);
        handshake("rearmed", 1'b0);

        // frame_start coincident with a hit in ARMED, and with the handshake itself.
        frame_pulse();
        coincide("fs_hit", 60, 60, 1'b1, 0, 0, 1'b1);
        handshake("fs_hs", 1'b1);
        coincide("after_fs_hs", 120, 60, 1'b1, 0, 1, 1'b0);
        hold("after_fs_hs", 1, 1'b0);
        handshake("after_fs_hs", 1'b0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
